// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: FSM encodings, default sizes and port indices.
// Used by mem_arbiter and arb2; the ARB_RR_EN build option lives in arb2.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam int   AW_DEF = 10;
    localparam int   DW_DEF = 32;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb2.sv
// Two-way grant logic. Macro ARB_RR_EN: round-robin on ties (pointer = port served last);
// otherwise fixed priority with port0 winning every tie and no pointer state.
module arb2
    import mem_arbiter_pkg::*;
(
`ifdef ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic grant_en,
`endif
    input  logic req0,
    input  logic req1,
    output logic gnt,
    output logic any_req
);

    assign any_req = req0 | req1;

`ifdef ARB_RR_EN
    logic last_q;
    logic last_d;

    // Reset value P1 makes port0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= P1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        if (req0 && req1) begin
            gnt = ~last_q;
        end else if (req0) begin
            gnt = P0;
        end else begin
            gnt = P1;
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant_en && any_req) begin
            last_d = gnt;
        end
    end
`else
    always_comb begin
        gnt = req0 ? P0 : P1;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port sync RAM; one access per 4 cycles.
// Build option ARB_RR_EN selects round-robin tie-breaking (see arb2); default is fixed priority.
//
// state | meaning
// IDLE  | arbitrate, register winner's op/addr/data toward the RAM
// ISSUE | RAM inputs stable, RAM writes/reads on the closing edge
// WAIT  | RAM dout valid, capture read data and raise ack
// ACK   | ack pulse visible to the granted port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          op_we_q, op_we_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          gnt_w;
    logic          any_req;

    arb2 u_arb2 (
`ifdef ARB_RR_EN
        .clk      (clk),
        .rst      (rst),
        .grant_en (state_q == ST_IDLE),
`endif
        .req0     (req0),
        .req1     (req1),
        .gnt      (gnt_w),
        .any_req  (any_req)
    );

    // Async reset also drops mem_we mid-ISSUE, so an in-flight write never lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= P0;
            op_we_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            op_we_q    <= op_we_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d      = gnt_q;
        op_we_d    = op_we_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d = gnt_w;
                    if (gnt_w == P0) begin
                        mem_we_d   = we0;
                        op_we_d    = we0;
                        mem_addr_d = addr0;
                        mem_din_d  = wdata0;
                    end else begin
                        mem_we_d   = we1;
                        op_we_d    = we1;
                        mem_addr_d = addr1;
                        mem_din_d  = wdata1;
                    end
                end
            end
            ST_WAIT: begin
                if (gnt_q == P0) begin
                    ack0_d = 1'b1;
                    if (!op_we_q) rdata0_d = mem_dout;
                end else begin
                    ack1_d = 1'b1;
                    if (!op_we_q) rdata1_d = mem_dout;
                end
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a behavioural RAM stage and a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    logic          clk;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, busy, mem_we;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_exp  [2];
`ifdef ARB_RR_EN
    logic          last_m;
`endif
    logic          prev_we;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .ack0     (ack0),
        .rdata0   (rdata0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .ack1     (ack1),
        .rdata1   (rdata1),
        .busy     (busy),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM stage: synchronous write, registered read (read-before-write).
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mem_we may only be seen while busy and never two cycles running.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            check("mon_we_busy", {31'd0, busy}, 32'd1);
            check("mon_we_single", {31'd0, prev_we}, 32'd0);
        end
        prev_we <= mem_we;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic op_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_t o;
        o.we = w; o.addr = a; o.data = d;
        return o;
    endfunction

    // Reference arbitration: who is served among pending ports.
    function automatic logic pick(input logic p0, input logic p1);
        logic w;
        if (p0 && p1) begin
`ifdef ARB_RR_EN
            w = ~last_m;
`else
            w = 1'b0;
`endif
        end else begin
            w = p0 ? 1'b0 : 1'b1;
        end
`ifdef ARB_RR_EN
        last_m = w;
`endif
        return w;
    endfunction

    // One access starting in the current IDLE cycle; returns in its ack cycle.
    task automatic serve(input logic p, input op_t op, input bit raise0);
        check("k0_busy", {31'd0, busy}, 0);
        check("k0_we", {31'd0, mem_we}, 0);
        check("k0_acks", {30'd0, ack1, ack0}, 0);
        if (op.we) ref_mem[op.addr] = op.data;
        else       rd_exp[p] = ref_mem[op.addr];
        step();
        check("k1_busy", {31'd0, busy}, 1);
        check("k1_we", {31'd0, mem_we}, {31'd0, op.we});
        check("k1_addr", {22'd0, mem_addr}, {22'd0, op.addr});
        check("k1_din", mem_din, op.data);
        check("k1_acks", {30'd0, ack1, ack0}, 0);
        if (raise0) req0 = 1'b1;
        step();
        check("k2_busy", {31'd0, busy}, 1);
        check("k2_we", {31'd0, mem_we}, 0);
        check("k2_acks", {30'd0, ack1, ack0}, 0);
        step();
        check("k3_busy", {31'd0, busy}, 1);
        check("k3_we", {31'd0, mem_we}, 0);
        check("k3_acks", {30'd0, ack1, ack0}, p ? 32'd2 : 32'd1);
        check("k3_rdata0", rdata0, rd_exp[0]);
        check("k3_rdata1", rdata1, rd_exp[1]);
    endtask

    // Raise requests in an IDLE cycle and serve them; late0 raises req0 mid-access of port1.
    task automatic do_pair(input bit r0, input op_t o0, input bit r1, input op_t o1, input bit late0);
        logic pend0, pend1, w;
        we0 = o0.we; addr0 = o0.addr; wdata0 = o0.data;
        we1 = o1.we; addr1 = o1.addr; wdata1 = o1.data;
        req0 = r0 && !late0;
        req1 = r1;
        pend0 = r0; pend1 = r1;
        for (int n = 0; n < 2; n++) begin
            if (pend0 || pend1) begin
                if (late0 && n == 0) w = pick(1'b0, 1'b1);
                else                 w = pick(pend0, pend1);
                serve(w, w ? o1 : o0, late0 && n == 0);
                step();
                if (w) begin req1 = 1'b0; pend1 = 1'b0; end
                else   begin req0 = 1'b0; pend0 = 1'b0; end
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ack"}, {30'd0, ack1, ack0}, 0);
        check({tag, "_rd0"}, rdata0, 0);
        check({tag, "_rd1"}, rdata1, 0);
        check({tag, "_we"}, {31'd0, mem_we}, 0);
        check({tag, "_addr"}, {22'd0, mem_addr}, 0);
        check({tag, "_din"}, mem_din, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_reset_vals("rst");
        req0 = 1'b0; req1 = 1'b0;
        step();
        rst = 1'b0;
`ifdef ARB_RR_EN
        last_m = 1'b1;
`endif
        rd_exp[0] = '0;
        rd_exp[1] = '0;
        step();
    endtask

    logic [AW-1:0] aset [8];
    op_t           z, oa, ob;
    bit            r0, r1, lt;

    initial begin
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        z = mk(1'b0, '0, '0);
`ifdef ARB_RR_EN
        last_m = 1'b1;
`endif
        rd_exp[0] = '0;
        rd_exp[1] = '0;
        repeat (2) step();
        check_reset_vals("por");
        rst = 1'b0;
        step();

        // 1) single-port write then read back
        do_pair(1, mk(1'b1, 10'h005, 32'hDEADBEEF), 0, z, 0);
        do_pair(1, mk(1'b0, 10'h005, 32'h0), 0, z, 0);
        check("t1_rdata0", rdata0, 32'hDEADBEEF);

        // 2) simultaneous reads, twice, from a fresh pointer
        do_reset();
        do_pair(1, mk(1'b0, 10'h005, 32'h0), 1, mk(1'b0, 10'h005, 32'h0), 0);
        do_pair(1, mk(1'b0, 10'h005, 32'h0), 1, mk(1'b0, 10'h005, 32'h0), 0);

        // 3) port1 write while port0 waits, then port0 reads the new value
        do_pair(1, mk(1'b0, 10'h3FF, 32'h0), 1, mk(1'b1, 10'h3FF, 32'h12345678), 1);
        check("t3_rdata0", rdata0, 32'h12345678);

        // 4) reset during ISSUE of a write aborts it
        do_pair(1, mk(1'b1, 10'h010, 32'hAAAA0000), 0, z, 0);
        we0 = 1'b1; addr0 = 10'h010; wdata0 = 32'h5555FFFF; req0 = 1'b1;
        step();
        check("t4_issue_we", {31'd0, mem_we}, 1);
        #2;
        do_reset();
        do_pair(1, mk(1'b0, 10'h010, 32'h0), 0, z, 0);
        check("t4_rdata0", rdata0, 32'hAAAA0000);

        // 5) a write never disturbs held read data
        do_pair(0, z, 1, mk(1'b1, 10'h020, 32'h11111111), 0);
        do_pair(1, mk(1'b0, 10'h020, 32'h0), 0, z, 0);
        do_pair(1, mk(1'b1, 10'h020, 32'h22222222), 0, z, 0);
        check("t5_rdata0", rdata0, 32'h11111111);

        // 6) back-to-back reads with req0 held high
        we0 = 1'b0; req0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr0 = (i[0]) ? 10'h020 : 10'h005;
            serve(1'b0, mk(1'b0, addr0, wdata0), 0);
            void'(pick(1'b1, 1'b0));
            step();
        end
        req0 = 1'b0;
        step();

        // randomized traffic over a small address set
        for (int i = 0; i < 8; i++) begin
            aset[i] = AW'($urandom_range(0, (1 << AW) - 1));
            do_pair(1, mk(1'b1, aset[i], $urandom), 0, z, 0);
        end
        for (int i = 0; i < 40; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            lt = r0 && r1 && ($urandom_range(0, 3) == 0);
            oa = mk(1'($urandom_range(0, 1)), aset[$urandom_range(0, 7)], $urandom);
            ob = mk(1'($urandom_range(0, 1)), aset[$urandom_range(0, 7)], $urandom);
            do_pair(r0, oa, r1, ob, lt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
